// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for an RV32 datapath: fetch, decode, execute,
// memory and write-back around a shared single-port memory, with a sticky fault trap.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic [6:0]       i_opcode,
  input  logic             i_branch_taken,
  input  logic             i_mem_ready,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic             o_reg_wen_gate,
  output logic             o_mem_req,
  output logic             o_mem_write,
  output logic             o_mem_addr_sel,
  output logic             o_fault,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_retire_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_ALU    = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_BRANCH = 3'd4
  } cls_t;

  function automatic cls_t decode_cls(input logic [6:0] opc);
    case (opc)
      7'b0110011, 7'b0010011: decode_cls = C_ALU;
      7'b0000011:             decode_cls = C_LOAD;
      7'b0100011:             decode_cls = C_STORE;
      7'b1100011:             decode_cls = C_BRANCH;
      default:                decode_cls = C_NONE;
    endcase
  endfunction

  state_t            r_state;
  state_t            w_seq_next;
  state_t            w_next;
  cls_t              r_cls;
  cls_t              w_dec_cls;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic              w_wait_hit;
  logic              w_retire;

  assign w_dec_cls    = decode_cls(i_opcode);
  assign w_wait_hit   = (r_wait_cnt == WAIT_LIMIT);
  assign w_next       = w_retire ? (i_run ? S_FETCH : S_IDLE) : w_seq_next;
  assign o_state      = r_state;
  assign o_retire_cnt = r_retire_cnt;

  // State, latched instruction class, memory wait counter and retire counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cls        <= C_NONE;
      r_wait_cnt   <= {WAIT_W{1'b0}};
      r_retire_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_cls <= w_dec_cls;
      end
      if (((r_state == S_FETCH) || (r_state == S_MEM)) && !i_mem_ready) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end else begin
        r_wait_cnt <= {WAIT_W{1'b0}};
      end
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state and strobe decode; a ready response wins over an expiring timeout.
  always_comb begin
    w_seq_next     = r_state;
    w_retire       = 1'b0;
    o_ir_write     = 1'b0;
    o_pc_write     = 1'b0;
    o_reg_wen_gate = 1'b0;
    o_mem_req      = 1'b0;
    o_mem_write    = 1'b0;
    o_mem_addr_sel = 1'b0;
    o_fault        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run) w_seq_next = S_FETCH;
        else       w_seq_next = S_IDLE;
      end
      S_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          w_seq_next = S_DECODE;
        end else if (w_wait_hit) begin
          w_seq_next = S_FAULT;
        end else begin
          w_seq_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (w_dec_cls == C_NONE) w_seq_next = S_FAULT;
        else                     w_seq_next = S_EXEC;
      end
      S_EXEC: begin
        // PC advances for every legal instruction, to the target or to PC+4.
        o_pc_write = (r_cls != C_NONE) || i_branch_taken;
        case (r_cls)
          C_ALU:           w_seq_next = S_WB;
          C_LOAD, C_STORE: w_seq_next = S_MEM;
          C_BRANCH:        w_retire   = 1'b1;
          default:         w_seq_next = S_FAULT;
        endcase
      end
      S_MEM: begin
        o_mem_req      = 1'b1;
        o_mem_addr_sel = 1'b1;
        o_mem_write    = (r_cls == C_STORE);
        if (i_mem_ready) begin
          if (r_cls == C_LOAD) w_seq_next = S_WB;
          else                 w_retire   = 1'b1;
        end else if (w_wait_hit) begin
          w_seq_next = S_FAULT;
        end else begin
          w_seq_next = S_MEM;
        end
      end
      S_WB: begin
        o_reg_wen_gate = 1'b1;
        w_retire       = 1'b1;
      end
      S_FAULT: begin
        o_fault    = 1'b1;
        w_seq_next = S_FAULT;
      end
      default: w_seq_next = S_FAULT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: the stimulus queues hand-derived per-cycle
// expectations and a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_sequencer;

  localparam int CW = 4;
  localparam logic [2:0] S_I = 3'd0, S_F = 3'd1, S_D = 3'd2, S_E = 3'd3;
  localparam logic [2:0] S_M = 3'd4, S_W = 3'd5, S_X = 3'd7;
  // strobe order {ir_write, pc_write, reg_wen_gate, mem_req, mem_write, addr_sel, fault}
  localparam logic [6:0] SB_0  = 7'b0000000, SB_FR = 7'b1001000, SB_FW = 7'b0001000;
  localparam logic [6:0] SB_EX = 7'b0100000, SB_MR = 7'b0001010, SB_MW = 7'b0001110;
  localparam logic [6:0] SB_WB = 7'b0010000, SB_FL = 7'b0000001;
  localparam logic [6:0] OP_ADD = 7'b0110011, OP_ADDI = 7'b0010011, OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011, OP_BEQ = 7'b1100011, OP_BAD = 7'b0000000;

  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, rdy = 1'b0, br = 1'b0;
  logic [6:0] opc = 7'd0;
  logic ir_write, pc_write, reg_wen, mem_req, mem_write, addr_sel, fault;
  logic [2:0] state;
  logic [CW-1:0] retire_cnt;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(15), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_run(run), .i_opcode(opc), .i_branch_taken(br),
    .i_mem_ready(rdy), .o_ir_write(ir_write), .o_pc_write(pc_write),
    .o_reg_wen_gate(reg_wen), .o_mem_req(mem_req), .o_mem_write(mem_write),
    .o_mem_addr_sel(addr_sel), .o_fault(fault), .o_state(state), .o_retire_cnt(retire_cnt)
  );

  typedef struct {
    logic [2:0]    st;
    logic [6:0]    sb;
    logic [CW-1:0] cnt;
    string         nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;
  logic [CW-1:0] ec = '0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // One clock of stimulus with its expected outputs queued for the monitor.
  task automatic cyc(input logic r, input logic m, input logic [2:0] st,
                     input logic [6:0] sb, input string nm);
    exp_t e;
    run = r; rdy = m;
    e.st = st; e.sb = sb; e.cnt = ec; e.nm = nm;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; rdy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ec = '0;
  endtask

  task automatic fetch_decode(input logic [6:0] o, input string nm);
    opc = o;
    cyc(1'b1, 1'b1, S_F, SB_FR, {nm, "_fetch"});
    cyc(1'b1, 1'b1, S_D, SB_0, {nm, "_decode"});
  endtask

  // Monitor: pops one expectation per sampled cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.nm, "_state"}, int'(state), int'(e.st));
      chk({e.nm, "_strobes"}, int'({ir_write, pc_write, reg_wen, mem_req, mem_write,
                                     addr_sel, fault}), int'(e.sb));
      chk({e.nm, "_retire_cnt"}, int'(retire_cnt), int'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, 1'b0, S_I, SB_0, "reset_idle");
    cyc(1'b0, 1'b1, S_I, SB_0, "idle_hold");
    cyc(1'b1, 1'b0, S_I, SB_0, "idle_start");

    fetch_decode(OP_ADD, "add");
    cyc(1'b1, 1'b1, S_E, SB_EX, "add_exec");
    cyc(1'b1, 1'b1, S_W, SB_WB, "add_wb"); ec = 4'd1;

    fetch_decode(OP_ADDI, "addi");
    cyc(1'b1, 1'b1, S_E, SB_EX, "addi_exec");
    cyc(1'b1, 1'b1, S_W, SB_WB, "addi_wb"); ec = 4'd2;

    fetch_decode(OP_LW, "lw");
    cyc(1'b1, 1'b0, S_E, SB_EX, "lw_exec");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, S_M, SB_MR, "lw_mem_wait");
    cyc(1'b1, 1'b1, S_M, SB_MR, "lw_mem_done");
    cyc(1'b1, 1'b1, S_W, SB_WB, "lw_wb"); ec = 4'd3;

    fetch_decode(OP_SW, "sw");
    cyc(1'b1, 1'b1, S_E, SB_EX, "sw_exec");
    cyc(1'b1, 1'b0, S_M, SB_MW, "sw_mem_wait");
    cyc(1'b1, 1'b1, S_M, SB_MW, "sw_mem_done"); ec = 4'd4;

    fetch_decode(OP_BEQ, "beq");
    br = 1'b1;
    cyc(1'b1, 1'b1, S_E, SB_EX, "beq_exec"); ec = 4'd5;
    br = 1'b0;

    fetch_decode(OP_ADD, "rundrop");
    cyc(1'b0, 1'b1, S_E, SB_EX, "rundrop_exec");
    cyc(1'b0, 1'b1, S_W, SB_WB, "rundrop_wb"); ec = 4'd6;
    cyc(1'b0, 1'b1, S_I, SB_0, "rundrop_idle");
    cyc(1'b1, 1'b0, S_I, SB_0, "restart_idle");

    opc = OP_ADD;
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, S_F, SB_FW, "late_fetch_wait");
    cyc(1'b1, 1'b1, S_F, SB_FR, "late_fetch_ready");
    cyc(1'b1, 1'b1, S_D, SB_0, "late_decode");
    cyc(1'b1, 1'b1, S_E, SB_EX, "late_exec");
    cyc(1'b1, 1'b1, S_W, SB_WB, "late_wb"); ec = 4'd7;

    for (int i = 0; i < 9; i++) begin
      fetch_decode(OP_BEQ, "wrap");
      cyc(1'b1, 1'b1, S_E, SB_EX, "wrap_exec");
      ec = ec + 4'd1;
    end
    ec = 4'd0;
    fetch_decode(OP_ADD, "postwrap");
    cyc(1'b1, 1'b1, S_E, SB_EX, "postwrap_exec");
    cyc(1'b1, 1'b1, S_W, SB_WB, "postwrap_wb"); ec = 4'd1;

    fetch_decode(OP_BAD, "illegal");
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, S_X, SB_FL, "illegal_fault_hold");
    do_reset();
    cyc(1'b0, 1'b0, S_I, SB_0, "fault_reset_idle");

    cyc(1'b1, 1'b0, S_I, SB_0, "timeout_idle");
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, S_F, SB_FW, "timeout_fetch_wait");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, S_X, SB_FL, "timeout_fault");
    do_reset();

    cyc(1'b1, 1'b0, S_I, SB_0, "midrst_idle");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, S_F, SB_FW, "midrst_fetch_wait");
    do_reset();
    cyc(1'b0, 1'b1, S_I, SB_0, "midrst_after");

    @(posedge clk); #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
